fir_x_feeder: RTL
=================

FIR_X_FEEDER -- requirements
Module: fir_x_feeder

Interface
REQ-001 Parameter DATA_W, default 32, width of sample bus.
REQ-002 Parameter DEPTH, default 4, sample FIFO depth, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  upstream sample offered.
REQ-006 s_ready  output  1  feeder can accept a sample this cycle.
REQ-007 s_data  input  DATA_W  upstream sample, two's complement.
REQ-008 x_rsc_dat  output  DATA_W  sample presented to fir input port.
REQ-009 x_triosy_lz  input  1  one-cycle pulse from fir: presented sample consumed.
REQ-010 level  output  clog2(DEPTH)+1  FIFO occupancy, excluding presented sample.
REQ-011 underrun_cnt  output  16  count of consumptions with no valid sample loaded.

Function
REQ-012 Upstream transfer occurs on a cycle with s_valid=1 and s_ready=1; s_ready SHALL be 1 iff level<DEPTH.
REQ-013 Two states: EMPTY (no sample loaded, x_rsc_dat=0) and LOADED (x_rsc_dat holds current sample).
REQ-014 EMPTY->LOADED: upstream transfer in EMPTY with level=0 SHALL load s_data directly into x_rsc_dat at the next edge (1-cycle latency), bypassing the FIFO.
REQ-015 LOADED, x_triosy_lz=1, level>0: next FIFO head SHALL appear on x_rsc_dat at next edge; level decrements unless a simultaneous transfer occurs.
REQ-016 LOADED, x_triosy_lz=1, level=0, no transfer: go EMPTY, x_rsc_dat=0 at next edge.
REQ-017 LOADED, x_triosy_lz=1, level=0, simultaneous transfer: s_data loaded directly into x_rsc_dat, stay LOADED, level stays 0.
REQ-018 LOADED, x_triosy_lz=0: x_rsc_dat SHALL hold; transfers write the FIFO tail.
REQ-019 Simultaneous transfer and pop with level>0: level unchanged; order strictly FIFO.
REQ-020 EMPTY, x_triosy_lz=1: underrun_cnt increments by 1, saturating at 16'hFFFF; any simultaneous transfer still loads per REQ-014.
REQ-021 FIFO pointers wrap modulo DEPTH; no sample dropped or duplicated at wrap.
REQ-022 x_triosy_lz held high for k consecutive cycles counts as k consumptions.

Reset
REQ-023 rst=1 at an edge SHALL set: state EMPTY, x_rsc_dat=0, level=0, pointers=0, underrun_cnt=0; s_ready=1 in the following cycle.
REQ-024 While rst=1, upstream transfers and x_triosy_lz SHALL be ignored; FIFO contents discarded on reset mid-operation.

Structure
REQ-025 Package fir_pkg SHALL hold DATA_W default, DEPTH default, and the state enum (EMPTY, LOADED), shared with other FIR-path blocks.
REQ-026 Storage SHALL be one sub-module fir_sync_fifo (push/pop/full/empty/level, synchronous reset); fir_x_feeder holds only the presentation register, state, and underrun counter.

Verification
REQ-027 Reset, then push 32'h00000011 once -> x_rsc_dat=32'h00000011 one cycle later, level=0.
REQ-028 Push 11,22,33,44,55 with no pulses -> first loaded, level=4, s_ready=0 after 5th, 6th offer stalls; four pulses then yield 22,33,44,55 in order.
REQ-029 Pulse x_triosy_lz with nothing loaded 3 times -> underrun_cnt=3, x_rsc_dat=0.
REQ-030 Loaded 32'hAAAA0000, level=0, pulse and push 32'hBBBB0000 same cycle -> x_rsc_dat=32'hBBBB0000 next cycle, level=0, no underrun.
REQ-031 Stream 20 ascending samples 1..20 with pulse every cycle and pushes every cycle -> output sequence 1..20, no gaps across pointer wrap, underrun_cnt=0.
REQ-032 Level=3, assert rst one cycle -> x_rsc_dat=0, level=0, underrun_cnt=0, s_ready=1; next push appears after 1 cycle.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR-path definitions: default widths/depths,
// feeder state enum and a saturating counter helper.
package fir_pkg;

  localparam int FIR_DATA_W = 32;
  localparam int FIR_DEPTH  = 4;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } feed_state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, sync active-high reset.
// Ports: i_push/i_wdata write, i_pop advances head,
//        o_rdata = head, o_full/o_empty/o_level status.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [LW-1:0]     o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is never reset; level/pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/fir_x_feeder.sv
// Feeds FIR input port: presentation register + FIFO backlog.
// Ports: s_valid/s_ready/s_data upstream, x_rsc_dat/x_triosy_lz fir side,
//        level = FIFO occupancy, underrun_cnt = pops with nothing loaded.
module fir_x_feeder
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_DEPTH,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] x_rsc_dat,
  input  logic              x_triosy_lz,
  output logic [LW-1:0]     level,
  output logic [15:0]       underrun_cnt
);

  feed_state_e       r_state;
  logic [DATA_W-1:0] r_x;
  logic [15:0]       r_underrun;

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_xfer;
  logic              w_loaded;
  logic              w_push;
  logic              w_pop;

  assign w_xfer   = s_valid & ~w_full;
  assign w_loaded = (r_state == LOADED);

  // Pop only when a loaded sample is consumed and a backlog exists.
  assign w_pop  = ~rst & w_loaded & x_triosy_lz & ~w_empty;
  // Bypass the FIFO whenever the sample goes straight to x_rsc_dat.
  assign w_push = ~rst & w_xfer & w_loaded
                & ~(x_triosy_lz & w_empty);

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (s_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_x        <= '0;
      r_underrun <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (x_triosy_lz)
            r_underrun <= sat_inc16(r_underrun);
          if (w_xfer) begin
            r_x     <= s_data;
            r_state <= LOADED;
          end
        end
        LOADED: begin
          if (x_triosy_lz) begin
            if (!w_empty) begin
              r_x <= w_head;
            end else if (w_xfer) begin
              r_x <= s_data;
            end else begin
              r_x     <= '0;
              r_state <= EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign s_ready      = ~w_full;
  assign x_rsc_dat    = r_x;
  assign level        = w_level;
  assign underrun_cnt = r_underrun;

endmodule
